// File: rtl/patdet_pkg.sv
// Shared definitions for the serial pattern detector and its display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package patdet_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_CODE [0:9] = '{
    7'b1000000,
    7'b1111001,
    7'b0100100,
    7'b0110000,
    7'b0011001,
    7'b0010010,
    7'b0000010,
    7'b1111000,
    7'b0000000,
    7'b0010000
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000111;

endpackage

// File: rtl/pattern_count_disp_seg7.sv
// Combinational BCD to 7-segment decoder with a blanking input.
// Non-BCD codes show a distinct error glyph.
module seg7_decode
  import patdet_pkg::*;
(
  input  bcd_digit_t bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_ERR;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_CODE[0];
        4'd1:    seg = SEG_CODE[1];
        4'd2:    seg = SEG_CODE[2];
        4'd3:    seg = SEG_CODE[3];
        4'd4:    seg = SEG_CODE[4];
        4'd5:    seg = SEG_CODE[5];
        4'd6:    seg = SEG_CODE[6];
        4'd7:    seg = SEG_CODE[7];
        4'd8:    seg = SEG_CODE[8];
        4'd9:    seg = SEG_CODE[9];
        default: seg = SEG_ERR;
      endcase
    end
  end

endmodule

// File: rtl/pattern_count_disp.sv
// Serial pattern detector with BCD match counter and registered 7-seg bank.
// Define PATDET_LZ_BLANK_EN to blank leading zero digits on disp.
module pattern_count_disp
  import patdet_pkg::*;
#(
  parameter int PAT_W  = 4,
  parameter int DIGITS = 2,
  parameter int WRAP   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  din,
  input  logic [PAT_W-1:0]      pattern,
  input  logic [PAT_W-1:0]      mask,
  input  logic                  overlap,
  input  logic                  clr_count,
  output logic                  z,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   disp,
  output logic                  overflow
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_n;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_n;
  logic             match;

  bcd_digit_t [DIGITS-1:0] cnt;
  bcd_digit_t [DIGITS-1:0] cnt_inc;
  logic                    all9;
  logic                    inc_carry;

  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] seg_nxt;

  assign hist_n = {hist[PAT_W-2:0], din};
  assign fill_n = (fill == FILL_MAX) ? FILL_MAX : fill + FW'(1);
  assign match  = ena && (fill_n == FILL_MAX) &&
                  (((hist_n ^ pattern) & mask) == '0);

  // Non-overlap restarts fill so the next hit needs PAT_W fresh bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else begin
      z <= match;
      if (ena) begin
        hist <= hist_n;
        fill <= (match && !overlap) ? '0 : fill_n;
      end
    end
  end

  always_comb begin
    cnt_inc   = cnt;
    inc_carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (inc_carry) begin
        if (cnt[k] == 4'd9) begin
          cnt_inc[k] = 4'd0;
        end else begin
          cnt_inc[k] = cnt[k] + 4'd1;
          inc_carry  = 1'b0;
        end
      end
    end
    all9 = inc_carry;
  end

  // Clear beats a coincident match; z still pulses from the match path.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clr_count) begin
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (match) begin
      if (all9) begin
        overflow <= 1'b1;
        if (WRAP != 0) cnt <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

  assign count_bcd = cnt;

`ifdef PATDET_LZ_BLANK_EN
  logic lz_seen;

  always_comb begin
    lz_seen = 1'b0;
    blank   = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      lz_seen  = lz_seen | (cnt[k] != 4'd0);
      blank[k] = ~lz_seen;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    seg7_decode u_dec (
      .bcd   (cnt[k]),
      .blank (blank[k]),
      .seg   (seg_nxt[7*k +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= {DIGITS{SEG_CODE[0]}};
    end else begin
      disp <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_count_disp.sv
// Bench for pattern_count_disp: table vectors, directed corners, random vs model.
// Runs a saturating and a wrapping instance side by side.
module tb_pattern_count_disp;

  localparam int PW   = 4;
  localparam int DIG  = 2;
  localparam int MAXC = 99;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b0;
  logic din = 1'b0;
  logic overlap = 1'b0;
  logic clr_count = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic [PW-1:0] mask = '0;

  logic          z0, z1, ovf0, ovf1;
  logic [7:0]    cnt0, cnt1;
  logic [13:0]   disp0, disp1;

  int nchk = 0;
  int nerr = 0;

  int          q[$];
  int          m_cnt[2];
  bit          m_ovf[2];
  bit          m_z;
  logic [13:0] m_disp[2];

  always #5 clk = ~clk;

  pattern_count_disp #(.PAT_W(PW), .DIGITS(DIG), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .din(din),
    .pattern(pattern), .mask(mask), .overlap(overlap),
    .clr_count(clr_count), .z(z0), .count_bcd(cnt0),
    .disp(disp0), .overflow(ovf0)
  );

  pattern_count_disp #(.PAT_W(PW), .DIGITS(DIG), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .din(din),
    .pattern(pattern), .mask(mask), .overlap(overlap),
    .clr_count(clr_count), .z(z1), .count_bcd(cnt1),
    .disp(disp1), .overflow(ovf1)
  );

  function automatic logic [6:0] seg(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0000111;
    endcase
  endfunction

  function automatic logic [13:0] disp_of(int n);
    logic [13:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < DIG; k++) begin
      r[7*k +: 7] = seg((n / p) % 10);
`ifdef PATDET_LZ_BLANK_EN
      if (k > 0 && n < p) r[7*k +: 7] = 7'b1111111;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(int n);
    return {4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int v;
    bit hit;
    hit = 1'b0;
    for (int w = 0; w < 2; w++)
      m_disp[w] = rst ? disp_of(0) : disp_of(m_cnt[w]);
    if (rst) begin
      q.delete();
      m_cnt = '{0, 0};
      m_ovf = '{0, 0};
      m_z = 1'b0;
      return;
    end
    if (ena) begin
      q.push_back(int'(din));
      if (q.size() > PW) void'(q.pop_front());
      if (q.size() == PW) begin
        v = 0;
        foreach (q[i]) v = v * 2 + q[i];
        hit = ((v ^ int'(pattern)) & int'(mask)) == 0;
        if (hit && !overlap) q.delete();
      end
    end
    m_z = hit;
    for (int w = 0; w < 2; w++) begin
      if (clr_count) begin
        m_cnt[w] = 0;
        m_ovf[w] = 1'b0;
      end else if (hit) begin
        if (m_cnt[w] == MAXC) begin
          m_ovf[w] = 1'b1;
          if (w == 1) m_cnt[w] = 0;
        end else begin
          m_cnt[w]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("z_sat",     32'(z0),    32'(m_z));
    chk("z_wrap",    32'(z1),    32'(m_z));
    chk("cnt_sat",   32'(cnt0),  32'(to_bcd(m_cnt[0])));
    chk("cnt_wrap",  32'(cnt1),  32'(to_bcd(m_cnt[1])));
    chk("ovf_sat",   32'(ovf0),  32'(m_ovf[0]));
    chk("ovf_wrap",  32'(ovf1),  32'(m_ovf[1]));
    chk("disp_sat",  32'(disp0), 32'(m_disp[0]));
    chk("disp_wrap", 32'(disp1), 32'(m_disp[1]));
  endtask

  task automatic step(input bit e, input bit d, input bit c);
    ena = e;
    din = d;
    clr_count = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    ena = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
  endtask

  typedef struct {
    bit rst;
    bit ena;
    bit din;
    bit ovl;
    bit z;
    int cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [13:0] exp_d;

    tbl[0]  = '{1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 1, 1};
    tbl[5]  = '{0, 1, 0, 0, 0, 1};
    tbl[6]  = '{0, 1, 1, 0, 0, 1};
    tbl[7]  = '{1, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 1, 0, 1, 0, 0};
    tbl[9]  = '{0, 1, 1, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 0, 0};
    tbl[11] = '{0, 1, 1, 1, 1, 1};
    tbl[12] = '{0, 1, 0, 1, 0, 1};
    tbl[13] = '{0, 1, 1, 1, 1, 2};

    pattern = 4'b0101;
    mask    = 4'b1111;
    m_cnt   = '{0, 0};
    m_ovf   = '{0, 0};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      overlap = tbl[i].ovl;
      step(tbl[i].ena, tbl[i].din, 1'b0);
      rst = 1'b0;
      chk("tbl_z",   32'(z0),   32'(tbl[i].z));
      chk("tbl_cnt", 32'(cnt0), 32'(to_bcd(tbl[i].cnt)));
    end
`ifdef PATDET_LZ_BLANK_EN
    exp_d = {7'b1111111, 7'b0100100};
`else
    exp_d = {7'b1000000, 7'b0100100};
`endif
    step(1'b0, 1'b0, 1'b0);
    chk("disp_two", 32'(disp0), 32'(exp_d));

    // don't-care mask: 1xx1
    do_reset();
    pattern = 4'b1001;
    mask    = 4'b1001;
    overlap = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("dc_nofill", 32'(z0), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("dc_hit1", 32'(z0), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    chk("dc_hit2", 32'(z0), 32'd1);
    chk("dc_cnt", 32'(cnt0), 32'h02);

    // saturation and wrap: all-zero mask matches every filled bit
    do_reset();
    mask = 4'b0000;
    overlap = 1'b1;
    for (int i = 0; i < 103; i++) step(1'b1, 1'(i), 1'b0);
    chk("sat_cnt",  32'(cnt0), 32'h99);
    chk("sat_ovf",  32'(ovf0), 32'd1);
    chk("wrap_cnt", 32'(cnt1), 32'h00);
    chk("wrap_ovf", 32'(ovf1), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("ena_low_z", 32'(z0), 32'd0);

    // clear wins over a coincident match
    step(1'b1, 1'b0, 1'b1);
    chk("clr_z",   32'(z0),   32'd1);
    chk("clr_cnt", 32'(cnt0), 32'h00);
    chk("clr_ovf", 32'(ovf0), 32'd0);

    // reset after three bits of 0101
    do_reset();
    pattern = 4'b0101;
    mask    = 4'b1111;
    overlap = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("rst_noz", 32'(z0), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'h00);
`ifdef PATDET_LZ_BLANK_EN
    exp_d = {7'b1111111, 7'b1000000};
`else
    exp_d = {7'b1000000, 7'b1000000};
`endif
    chk("rst_disp", 32'(disp0), 32'(exp_d));
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_noz3", 32'(z0), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_hit", 32'(z0), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        pattern = 4'($urandom);
        mask    = 4'($urandom);
      end
      if ($urandom_range(0, 29) == 0) overlap = 1'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 9) < 7, 1'($urandom),
           $urandom_range(0, 99) == 0);
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
